// File: rtl/lcd_cmd_sequencer.sv
// HD44780-style character LCD sequencer: power-up delay, fixed init ROM, then
// single-byte command/data writes with setup, enable-pulse and execution timing.
module lcd_cmd_sequencer #(
    parameter int PWRUP_CYC = 1000000,
    parameter int SETUP_CYC = 2,
    parameter int EN_CYC    = 25,
    parameter int CMD_CYC   = 2500,
    parameter int CLR_CYC   = 100000,
    parameter int CNT_W     = 20
) (
    input  logic       iCLK,
    input  logic       iRST_n,
    input  logic       iWR_REQ,
    input  logic       iRS,
    input  logic [7:0] iDATA,
    output logic       oREADY,
    output logic       oINIT_DONE,
    output logic [7:0] oLCD_DATA,
    output logic       oLCD_RS,
    output logic       oLCD_RW,
    output logic       oLCD_EN
);

    localparam logic [CNT_W-1:0] L_PWRUP = CNT_W'(PWRUP_CYC);
    localparam logic [CNT_W-1:0] L_SETUP = CNT_W'(SETUP_CYC);
    localparam logic [CNT_W-1:0] L_EN    = CNT_W'(EN_CYC);
    localparam logic [CNT_W-1:0] L_CMD   = CNT_W'(CMD_CYC);
    localparam logic [CNT_W-1:0] L_CLR   = CNT_W'(CLR_CYC);
    localparam logic [CNT_W-1:0] L_ONE   = CNT_W'(1);
    localparam logic [2:0]       L_LAST  = 3'd4;

    typedef enum logic [2:0] {
        S_PWRUP,
        S_SETUP,
        S_PULSE,
        S_WAIT,
        S_IDLE
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]       r_idx, w_idx_nxt;
    logic [7:0]       r_data, w_data_nxt;
    logic             r_rs, w_rs_nxt;
    logic             r_en;
    logic             r_ready;
    logic             r_init_done, w_init_done_nxt;
    logic             w_done;
    logic             w_long;

    function automatic logic [7:0] f_rom(input logic [2:0] idx);
        case (idx)
            3'd0:    f_rom = 8'h38;
            3'd1:    f_rom = 8'h38;
            3'd2:    f_rom = 8'h0C;
            3'd3:    f_rom = 8'h01;
            3'd4:    f_rom = 8'h06;
            default: f_rom = 8'h00;
        endcase
    endfunction

    // Exiting on count 1 (while the counter steps to 0) makes each phase last
    // exactly its programmed number of clocks.
    assign w_done = (r_cnt <= L_ONE);

    // Clear and return-home commands need the long execution wait.
    assign w_long = !r_rs && (r_data == 8'h01 || r_data == 8'h02 || r_data == 8'h03);

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt - L_ONE;
        w_idx_nxt       = r_idx;
        w_data_nxt      = r_data;
        w_rs_nxt        = r_rs;
        w_init_done_nxt = r_init_done;
        case (r_state)
            S_PWRUP: begin
                if (w_done) begin
                    w_state_nxt = S_SETUP;
                    w_cnt_nxt   = L_SETUP;
                    w_idx_nxt   = 3'd0;
                    w_data_nxt  = f_rom(3'd0);
                    w_rs_nxt    = 1'b0;
                end
            end
            S_SETUP: begin
                if (w_done) begin
                    w_state_nxt = S_PULSE;
                    w_cnt_nxt   = L_EN;
                end
            end
            S_PULSE: begin
                if (w_done) begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = w_long ? L_CLR : L_CMD;
                end
            end
            S_WAIT: begin
                if (w_done) begin
                    w_idx_nxt = r_idx + 3'd1;
                    if (!r_init_done && r_idx != L_LAST) begin
                        w_state_nxt = S_SETUP;
                        w_cnt_nxt   = L_SETUP;
                        w_data_nxt  = f_rom(r_idx + 3'd1);
                        w_rs_nxt    = 1'b0;
                    end else begin
                        w_state_nxt     = S_IDLE;
                        w_cnt_nxt       = '0;
                        w_init_done_nxt = 1'b1;
                    end
                end
            end
            S_IDLE: begin
                w_cnt_nxt = r_cnt;
                if (iWR_REQ) begin
                    w_state_nxt = S_SETUP;
                    w_cnt_nxt   = L_SETUP;
                    w_data_nxt  = iDATA;
                    w_rs_nxt    = iRS;
                end
            end
            default: begin
                w_state_nxt = S_PWRUP;
                w_cnt_nxt   = L_PWRUP;
            end
        endcase
    end

    // EN and READY are registered from the next state so they line up with it.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_state     <= S_PWRUP;
            r_cnt       <= L_PWRUP;
            r_idx       <= 3'd0;
            r_data      <= 8'h00;
            r_rs        <= 1'b0;
            r_en        <= 1'b0;
            r_ready     <= 1'b0;
            r_init_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_data      <= w_data_nxt;
            r_rs        <= w_rs_nxt;
            r_en        <= (w_state_nxt == S_PULSE);
            r_ready     <= (w_state_nxt == S_IDLE);
            r_init_done <= w_init_done_nxt;
        end
    end

    assign oREADY     = r_ready;
    assign oINIT_DONE = r_init_done;
    assign oLCD_DATA  = r_data;
    assign oLCD_RS    = r_rs;
    assign oLCD_RW    = 1'b0;
    assign oLCD_EN    = r_en;

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Bench for lcd_cmd_sequencer: expected pulse times/bytes are computed from the
// phase durations and compared against EN pulses captured on the LCD bus.
module tb_lcd_cmd_sequencer;

    localparam int PWRUP = 20;
    localparam int SETUP = 2;
    localparam int EN    = 4;
    localparam int CMD   = 10;
    localparam int CLR   = 30;

    logic       iCLK;
    logic       iRST_n;
    logic       iWR_REQ;
    logic       iRS;
    logic [7:0] iDATA;
    logic       oREADY;
    logic       oINIT_DONE;
    logic [7:0] oLCD_DATA;
    logic       oLCD_RS;
    logic       oLCD_RW;
    logic       oLCD_EN;

    lcd_cmd_sequencer #(
        .PWRUP_CYC(PWRUP), .SETUP_CYC(SETUP), .EN_CYC(EN),
        .CMD_CYC(CMD), .CLR_CYC(CLR), .CNT_W(20)
    ) dut (
        .iCLK(iCLK), .iRST_n(iRST_n), .iWR_REQ(iWR_REQ), .iRS(iRS), .iDATA(iDATA),
        .oREADY(oREADY), .oINIT_DONE(oINIT_DONE), .oLCD_DATA(oLCD_DATA),
        .oLCD_RS(oLCD_RS), .oLCD_RW(oLCD_RW), .oLCD_EN(oLCD_EN)
    );

    initial begin
        iCLK = 1'b0;
        forever #5 iCLK = ~iCLK;
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_chg = -100;
    int rise_cyc = 0;
    int rdy_cyc = -1;
    logic       p_en = 1'b0;
    logic       p_rs = 1'b0;
    logic       p_rdy = 1'b0;
    logic [7:0] p_dat = 8'h00;
    int         ev_cyc[$];
    logic [7:0] ev_dat[$];
    logic       ev_rs[$];
    logic [7:0] rom[5];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int wt(input logic rs, input logic [7:0] d);
        return (!rs && d >= 8'h01 && d <= 8'h03) ? CLR : CMD;
    endfunction

    // One clock: advance, then observe at the falling edge and track the bus.
    task automatic tick();
        @(posedge iCLK);
        cyc++;
        @(negedge iCLK);
        chk("rw_low", oLCD_RW, 0);
        if ((oLCD_DATA !== p_dat) || (oLCD_RS !== p_rs)) begin
            chk("bus_change_under_en", oLCD_EN, 0);
            last_chg = cyc;
        end
        if (oLCD_EN && !p_en) begin
            ev_cyc.push_back(cyc);
            ev_dat.push_back(oLCD_DATA);
            ev_rs.push_back(oLCD_RS);
            rise_cyc = cyc;
            chk("bus_setup_before_en", (cyc - last_chg) >= SETUP, 1);
        end
        if (!oLCD_EN && p_en) chk("en_width", cyc - rise_cyc, EN);
        if (oREADY && !p_rdy) rdy_cyc = cyc;
        p_en  = oLCD_EN;
        p_dat = oLCD_DATA;
        p_rs  = oLCD_RS;
        p_rdy = oREADY;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_en"},   oLCD_EN, 0);
        chk({tag, "_data"}, oLCD_DATA, 0);
        chk({tag, "_rs"},   oLCD_RS, 0);
        chk({tag, "_rw"},   oLCD_RW, 0);
        chk({tag, "_rdy"},  oREADY, 0);
        chk({tag, "_done"}, oINIT_DONE, 0);
    endtask

    // Assumes iRST_n is already low; releases it at a falling edge as cycle 0.
    task automatic release_reset();
        @(negedge iCLK);
        @(negedge iCLK);
        iRST_n = 1'b1;
        cyc = 0;
        last_chg = -100;
        rdy_cyc = -1;
        p_en = 1'b0; p_rs = 1'b0; p_rdy = 1'b0; p_dat = 8'h00;
        ev_cyc.delete(); ev_dat.delete(); ev_rs.delete();
    endtask

    // Requests are held high with random bytes throughout init; none may be taken.
    task automatic run_init(input string tag);
        int exp_c[5];
        int t;
        bit got;
        t = PWRUP;
        for (int i = 0; i < 5; i++) begin
            exp_c[i] = t + SETUP;
            t += SETUP + EN + wt(1'b0, rom[i]);
        end
        iWR_REQ = 1'b1;
        iRS = 1'($urandom);
        iDATA = 8'($urandom);
        got = 0;
        for (int k = 0; k < 400 && !got; k++) begin
            tick();
            if (oREADY) got = 1;
            else chk({tag, "_done_early"}, oINIT_DONE, 0);
            iDATA = 8'($urandom);
            iRS = 1'($urandom);
        end
        iWR_REQ = 1'b0;
        chk({tag, "_timeout"}, got, 1);
        chk({tag, "_ready_cyc"}, rdy_cyc, t);
        chk({tag, "_done"}, oINIT_DONE, 1);
        chk({tag, "_npulse"}, ev_cyc.size(), 5);
        for (int i = 0; i < 5 && i < ev_cyc.size(); i++) begin
            chk({tag, "_pulse_cyc"}, ev_cyc[i], exp_c[i]);
            chk({tag, "_pulse_data"}, ev_dat[i], rom[i]);
            chk({tag, "_pulse_rs"}, ev_rs[i], 0);
        end
    endtask

    // Accept at the next edge; ready and pulse timing follow from the byte's wait.
    task automatic do_write(input logic rs, input logic [7:0] d, input bit hold);
        int c, n0, exp_rdy;
        bit got;
        chk("wr_ready_pre", oREADY, 1);
        c = cyc;
        n0 = ev_cyc.size();
        iWR_REQ = 1'b1;
        iRS = rs;
        iDATA = d;
        tick();
        if (!hold) iWR_REQ = 1'b0;
        iRS = 1'($urandom);
        iDATA = 8'($urandom);
        chk("wr_ready_low", oREADY, 0);
        chk("wr_bus_data", oLCD_DATA, d);
        chk("wr_bus_rs", oLCD_RS, rs);
        got = 0;
        for (int k = 0; k < 300 && !got; k++) begin
            tick();
            if (oREADY) got = 1;
        end
        iWR_REQ = 1'b0;
        exp_rdy = c + 1 + SETUP + EN + wt(rs, d);
        chk("wr_timeout", got, 1);
        chk("wr_ready_cyc", rdy_cyc, exp_rdy);
        chk("wr_npulse", ev_cyc.size(), n0 + 1);
        if (ev_cyc.size() > n0) begin
            chk("wr_pulse_cyc", ev_cyc[n0], c + 1 + SETUP);
            chk("wr_pulse_data", ev_dat[n0], d);
            chk("wr_pulse_rs", ev_rs[n0], rs);
        end
        chk("wr_bus_hold", oLCD_DATA, d);
    endtask

    logic       dir_rs[6];
    logic [7:0] dir_d[6];

    initial begin
        rom = '{8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
        dir_rs = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        dir_d  = '{8'h41, 8'h01, 8'h80, 8'h02, 8'h03, 8'h01};
        iWR_REQ = 1'b0;
        iRS = 1'b0;
        iDATA = 8'h00;
        iRST_n = 1'b1;
        #2 iRST_n = 1'b0;
        #1 chk_reset("reset");
        release_reset();
        run_init("init");

        // Idle with no request: nothing happens, ready stays up.
        for (int k = 0; k < 5; k++) tick();
        chk("idle_npulse", ev_cyc.size(), 5);
        chk("idle_ready", oREADY, 1);

        for (int i = 0; i < 6; i++) do_write(dir_rs[i], dir_d[i], i[0]);
        for (int i = 0; i < 12; i++) begin
            logic       rs;
            logic [7:0] d;
            rs = 1'($urandom);
            d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
            for (int g = $urandom_range(0, 3); g > 0; g--) tick();
            do_write(rs, d, 1'($urandom));
        end

        // Reset in the middle of the second init pulse.
        iRST_n = 1'b0;
        #1 chk_reset("reset2");
        release_reset();
        begin
            bit got;
            got = 0;
            for (int k = 0; k < 200 && !got; k++) begin
                tick();
                if (ev_cyc.size() == 2) got = 1;
            end
            chk("midpulse_reach", got, 1);
        end
        tick();
        chk("midpulse_en", oLCD_EN, 1);
        #2 iRST_n = 1'b0;
        #1 chk_reset("midpulse_rst");
        release_reset();
        run_init("reinit");
        do_write(1'b1, 8'h41, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
